serial_compare_ctrl: RTL and testbench

Sequencing controller that compares two WIDTH-bit unsigned operands by stepping the team's 2-bit `comparator` cell across the operands, most-significant slice first. It sits between a requester issuing a start pulse and a shared narrow compare datapath. It exposes busy/done handshaking and registered less/equal/greater flags, so wide magnitude compares need only one small comparator instance.

---
 rtl/serial_compare_ctrl_if.sv | 23 ++
 rtl/serial_compare_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_compare_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// rtl/serial_compare_ctrl_if.sv - start/operand request and busy/done/result bundle
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_gt_b;

  modport master (
    output start, a, b,
    input  busy, done, a_lt_b, a_eq_b, a_gt_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_lt_b, a_eq_b, a_gt_b
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// rtl/serial_compare_ctrl.sv - MSB-first sliced magnitude compare over one 2-bit comparator cell
// Optional build macro EARLY_EXIT_EN: stop scanning at the first unequal slice.

module comparator (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);
  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_compare_ctrl_if.slave  bus
);
  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NSLICE - 1);
`ifdef EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             plt_q, plt_d, pgt_q, pgt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic cmp_lt, cmp_eq, cmp_gt;

  comparator u_cmp (
    .a  (ra_q[{idx_q, 1'b0} +: 2]),
    .b  (rb_q[{idx_q, 1'b0} +: 2]),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    plt_d     = plt_q;
    pgt_d     = pgt_q;
    done_d    = 1'b0;
    lt_d      = lt_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SCAN;
          ra_d      = bus.a;
          rb_d      = bus.b;
          idx_d     = IDX_MSB;
          decided_d = 1'b0;
          plt_d     = 1'b0;
          pgt_d     = 1'b0;
        end
      end
      SCAN: begin
        // First unequal slice from the top decides; later slices cannot override it.
        if (!cmp_eq && !decided_q) begin
          decided_d = 1'b1;
          plt_d     = cmp_lt;
          pgt_d     = cmp_gt;
        end
        if (idx_q == '0 || (EARLY_EXIT && !cmp_eq)) begin
          state_d = DONE;
          done_d  = 1'b1;
          lt_d    = plt_d;
          gt_d    = pgt_d;
          eq_d    = ~(plt_d | pgt_d);
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ra_q      <= '0;
      rb_q      <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      plt_q     <= 1'b0;
      pgt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      plt_q     <= plt_d;
      pgt_q     <= pgt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.a_lt_b = lt_q;
  assign bus.a_eq_b = eq_q;
  assign bus.a_gt_b = gt_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb/tb_serial_compare_ctrl.sv - directed and random compares against a golden unsigned compare
module tb_serial_compare_ctrl;
  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan cycles the compare should take, counted slice by slice from the MSB.
  function automatic int exp_k(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
`ifdef EARLY_EXIT_EN
    for (int j = 0; j < NSLICE; j++) begin
      if (((av >> (2 * (NSLICE - 1 - j))) & 3) != ((bv >> (2 * (NSLICE - 1 - j))) & 3))
        return j + 1;
    end
`endif
    return NSLICE;
  endfunction

  function automatic logic [2:0] golden(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    return {av < bv, av == bv, av > bv};
  endfunction

  // Entered and left on a negedge; the next call can start back-to-back.
  task automatic run_compare(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int         cyc;
    int         k;
    logic [2:0] prev;
    k    = exp_k(av, bv);
    prev = {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b};
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    cyc       = 1;
    while (bus.done !== 1'b1 && cyc < NSLICE + 4) begin
      check("busy_scan", bus.busy, 1);
      check("flags_hold", {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}, prev);
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, k + 1);
    check("busy_done", bus.busy, 1);
    check("flags", {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}, golden(av, bv));
    @(negedge clk);
    check("idle_after", {bus.busy, bus.done}, 0);
    check("flags_kept", {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}, golden(av, bv));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_compare(8'hA5, 8'hA5);
    run_compare(8'h80, 8'h7F);
    run_compare(8'h12, 8'h13);

    // Start pulse during SCAN must be ignored.
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h13;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy", bus.busy, 1);
    @(negedge clk);
    @(negedge clk);
    check("ign_done", bus.done, 1);
    check("ign_flags", {bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}, 3'b100);
    @(negedge clk);
    check("ign_idle", {bus.busy, bus.done}, 0);
    run_compare(8'hFF, 8'h00);

    // Reset mid-scan discards the compare.
    bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'hC0;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", {bus.busy, bus.done, bus.a_lt_b, bus.a_eq_b, bus.a_gt_b}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_done", {bus.busy, bus.done}, 0);
    end

    // Start together with reset is ignored.
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rststart_busy", bus.busy, 0);
    @(negedge clk);
    check("rststart_idle", {bus.busy, bus.done}, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: ;
      endcase
      run_compare(ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
